// File: rtl/key_schedule.sv
// AES-128 key expansion: latches a cipher key, then emits round keys 0..10.
// Build option: KEY_SCHEDULE_ZEROIZE_EN clears the key register after round 10.
module key_schedule (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         v_i,
  input  logic [127:0] key_i,
  output logic         ready_o,
  output logic         v_o,
  output logic [127:0] round_key_o,
  output logic [3:0]   round_o,
  input  logic         yumi_i
);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  localparam logic [3:0] LAST = 4'd10;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [31:0] sub_word(
    input logic [31:0] w
  );
    return {SBOX[w[31:24]], SBOX[w[23:16]],
            SBOX[w[15:8]],  SBOX[w[7:0]]};
  endfunction

  // Rcon for the round being produced, indexed by the current round
  function automatic logic [7:0] rcon(
    input logic [3:0] r
  );
    logic [7:0] c;
    case (r)
      4'd0:    c = 8'h01;
      4'd1:    c = 8'h02;
      4'd2:    c = 8'h04;
      4'd3:    c = 8'h08;
      4'd4:    c = 8'h10;
      4'd5:    c = 8'h20;
      4'd6:    c = 8'h40;
      4'd7:    c = 8'h80;
      4'd8:    c = 8'h1b;
      4'd9:    c = 8'h36;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  state_e       state_q;
  state_e       state_n;
  logic [127:0] key_q;
  logic [127:0] key_n;
  logic [3:0]   round_q;
  logic [3:0]   round_n;

  logic [31:0]  w0;
  logic [31:0]  w1;
  logic [31:0]  w2;
  logic [31:0]  w3;
  logic [31:0]  t;
  logic [31:0]  n0;
  logic [31:0]  n1;
  logic [31:0]  n2;
  logic [31:0]  n3;
  logic [127:0] key_next;

  assign {w0, w1, w2, w3} = key_q;

  assign t  = sub_word({w3[23:0], w3[31:24]})
            ^ {rcon(round_q), 24'h0};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign key_next = {n0, n1, n2, n3};

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      key_q   <= '0;
      round_q <= '0;
    end else begin
      state_q <= state_n;
      key_q   <= key_n;
      round_q <= round_n;
    end
  end

  always_comb begin
    state_n = state_q;
    key_n   = key_q;
    round_n = round_q;
    unique case (state_q)
      IDLE: begin
        if (v_i) begin
          key_n   = key_i;
          round_n = '0;
          state_n = EMIT;
        end
      end
      EMIT: begin
        if (yumi_i) begin
          if (round_q == LAST) begin
            state_n = IDLE;
            round_n = '0;
`ifdef KEY_SCHEDULE_ZEROIZE_EN
            key_n   = '0;
`else
            key_n   = key_q;
`endif
          end else begin
            key_n   = key_next;
            round_n = round_q + 4'd1;
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign ready_o     = (state_q == IDLE);
  assign v_o         = (state_q == EMIT);
  assign round_key_o = key_q;
  assign round_o     = round_q;

endmodule

// File: doc/key_schedule.md
KEY_SCHEDULE -- requirements
Module: key_schedule

Interface
REQ-001 The block SHALL have no parameters; it SHALL be fixed to AES-128 (Nk=4, 10 rounds).
REQ-002 clk_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset_i  input  1  reset; asynchronous and active-high.
REQ-004 v_i  input  1  cipher key on key_i is valid.
REQ-005 key_i  input  128  cipher key; bits [127:96] are word w0 and bits [31:0] are word w3.
REQ-006 ready_o  output  1  block can accept a new key.
REQ-007 v_o  output  1  round_key_o and round_o are valid.
REQ-008 round_key_o  output  128  current round key, in the same byte order as key_i; it feeds add_round_key.
REQ-009 round_o  output  4  index of the current round key, 0..10.
REQ-010 yumi_i  input  1  consumer takes the current round key; it is legal only while v_o=1.

Function
REQ-011 The FSM SHALL have two states: IDLE and EMIT.
REQ-012 ready_o SHALL be 1 exactly in IDLE, and v_o SHALL be 1 exactly in EMIT.
REQ-013 IDLE with v_i=1: the block SHALL latch key_i into the key register, set the round to 0 and move to EMIT.
  - Latency is 1 cycle.
  - On the next cycle v_o=1, round_o=0 and round_key_o=key_i.
REQ-014 EMIT with yumi_i=0: round_key_o and round_o SHALL hold stable for any number of cycles.
REQ-015 EMIT with yumi_i=1 and round_o<10: on that edge the key register SHALL load the next round key and round_o SHALL increment.
  - One round key per cycle when yumi_i is held high.
REQ-016 EMIT with yumi_i=1 and round_o=10: the block SHALL return to IDLE and round_o SHALL become 0.
  - ready_o=1 on the next cycle.
REQ-017 Next round key computation, with r = round_o before the increment:
  - t = SubWord(RotWord(w3)) XOR {Rcon[r+1], 24'h0}
  - w0' = w0^t, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'
  - Rcon[1..10] = 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
REQ-018 SubWord SHALL use the FIPS-197 S-box on four bytes in parallel, combinationally within one cycle.
REQ-019 Ignored inputs:
  - v_i while not in IDLE SHALL be ignored, and key_i SHALL NOT be sampled.
  - yumi_i while in IDLE SHALL be ignored.
REQ-020 round_key_o SHALL always drive the key register directly, with no combinational path from key_i.
  - In IDLE without the macro, it holds the last value.

Reset
REQ-021 reset_i=1 SHALL immediately, without waiting for a clock edge, force:
  - state IDLE, key register 0, round 0
  - v_o=0, ready_o=1, round_key_o=0, round_o=0.
REQ-022 Reset asserted mid-expansion SHALL abort the expansion; no partial output SHALL appear after reset releases.
REQ-023 After reset releases, the first rising edge with v_i=1 SHALL be accepted.

Configuration
REQ-024 Macro KEY_SCHEDULE_ZEROIZE_EN:
  - When defined: the key register SHALL be cleared to 0 on the same edge that ends round 10 (REQ-016), so round_key_o=0 in IDLE.
  - When undefined: the key register SHALL keep the round-10 key in IDLE.
  - All other behaviour SHALL be identical in both cases.

Verification
REQ-025 Reset check: assert reset_i with no clock edge -> ready_o=1, v_o=0, round_key_o=0, round_o=0.
REQ-026 Accept key 2b7e151628aed2a6abf7158809cf4f3c, then hold yumi_i=1 -> the following sequence, then ready_o=1 on the cycle after round 10:
  - round 0: 2b7e151628aed2a6abf7158809cf4f3c
  - round 1: a0fafe1788542cb123a339392a6c7605
  - round 10: d014f9a8c9ee2589e13f0cc8b6630ca6
  - 11 consecutive v_o cycles.
REQ-027 Accept key 000102030405060708090a0b0c0d0e0f with yumi_i pulsed every third cycle -> the following, with outputs stable between pulses:
  - round 1: d6aa74fdd2af72fadaa678f1d6ab76fe
  - round 10: 13111d7fe3944a17f307a78b4d2b30c5
REQ-028 In EMIT at round 3, drive v_i=1 with a different key_i and yumi_i=0 for 5 cycles -> round_o=3, round_key_o unchanged, ready_o=0 throughout. Then, in IDLE, pulse yumi_i -> no state change.
REQ-029 Assert reset_i asynchronously at round 5 -> v_o=0 and round_key_o=0 before the next edge. After release, key 2b7e... restarts cleanly at round 0.
REQ-030 Complete round 10 -> round_key_o in IDLE:
  - macro defined: 0
  - macro undefined: d014f9a8c9ee2589e13f0cc8b6630ca6.
